// File: rtl/reservation_station_pkg.sv
// Shared types and constants for the reservation station slice.
package reservation_station_pkg;

  localparam int unsigned RobW  = 4;
  localparam int unsigned OpW   = 6;
  localparam int unsigned DataW = 32;

  // Internal opcodes; the station only carries them through to the ALU.
  localparam logic [OpW-1:0] OpAdd   = 6'd1;
  localparam logic [OpW-1:0] OpSub   = 6'd2;
  localparam logic [OpW-1:0] OpBeq   = 6'd10;
  localparam logic [OpW-1:0] OpJalr  = 6'd20;
  localparam logic [OpW-1:0] OpLtype = 6'd30;

  // One source operand: value is meaningful once pending is clear.
  typedef struct packed {
    logic             pending;
    logic [DataW-1:0] value;
  } operand_t;

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch, CDB and issue signals of the reservation station.
interface reservation_station_if
  import reservation_station_pkg::*;
#(
  parameter int unsigned ROB_W = RobW
);
  logic             full;
  logic             disp_sgn;
  logic [OpW-1:0]   disp_opcode;
  logic [ROB_W-1:0] disp_rob_name;
  logic [DataW-1:0] disp_vj;
  logic [DataW-1:0] disp_vk;
  logic [ROB_W-1:0] disp_qj;
  logic [ROB_W-1:0] disp_qk;
  logic             disp_qj_busy;
  logic             disp_qk_busy;
  logic             alu_cdb_sgn;
  logic [ROB_W-1:0] alu_cdb_rob_name;
  logic [DataW-1:0] alu_cdb_result;
  logic             lsb_cdb_sgn;
  logic [ROB_W-1:0] lsb_cdb_rob_name;
  logic [DataW-1:0] lsb_cdb_result;
  logic             alu_sgn;
  logic [OpW-1:0]   alu_opcode;
  logic [ROB_W-1:0] alu_rob_name;
  logic [DataW-1:0] alu_lhs;
  logic [DataW-1:0] alu_rhs;

  // Dispatch/CDB producer side.
  modport master (
    input  full, alu_sgn, alu_opcode, alu_rob_name, alu_lhs, alu_rhs,
    output disp_sgn, disp_opcode, disp_rob_name, disp_vj, disp_vk, disp_qj, disp_qk,
           disp_qj_busy, disp_qk_busy, alu_cdb_sgn, alu_cdb_rob_name, alu_cdb_result,
           lsb_cdb_sgn, lsb_cdb_rob_name, lsb_cdb_result
  );

  // Reservation station side.
  modport slave (
    output full, alu_sgn, alu_opcode, alu_rob_name, alu_lhs, alu_rhs,
    input  disp_sgn, disp_opcode, disp_rob_name, disp_vj, disp_vk, disp_qj, disp_qk,
           disp_qj_busy, disp_qk_busy, alu_cdb_sgn, alu_cdb_rob_name, alu_cdb_result,
           lsb_cdb_sgn, lsb_cdb_rob_name, lsb_cdb_result
  );
endinterface

// File: rtl/reservation_station_pick.sv
// Lowest-index priority encoder: valid plus index of the first set request bit.
module reservation_station_pick #(
  parameter int unsigned N = 16,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [IdxW-1:0] idx
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds ops until operands arrive, issues one ready op per cycle.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int unsigned RS_SIZE = 16,
  parameter int unsigned ROB_W   = RobW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  clear,
  reservation_station_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(RS_SIZE);

  typedef struct packed {
    logic             busy;
    logic [OpW-1:0]   opcode;
    logic [ROB_W-1:0] rob_name;
    logic [ROB_W-1:0] qj;
    logic [ROB_W-1:0] qk;
    operand_t         j;
    operand_t         k;
  } entry_t;

  typedef struct packed {
    logic             sgn;
    logic [OpW-1:0]   opcode;
    logic [ROB_W-1:0] rob_name;
    logic [DataW-1:0] lhs;
    logic [DataW-1:0] rhs;
  } issue_t;

  entry_t ent_q [RS_SIZE];
  entry_t ent_d [RS_SIZE];
  issue_t alu_q, alu_d;

  logic [RS_SIZE-1:0] free_vec, ready_vec;
  logic               free_valid, ready_valid;
  logic [IdxW-1:0]    free_idx, ready_idx;

  // Capture a CDB value for a pending operand; the ALU bus wins over the load bus.
  function automatic operand_t snoop(operand_t op, logic [ROB_W-1:0] tag,
                                     logic a_sgn, logic [ROB_W-1:0] a_tag,
                                     logic [DataW-1:0] a_res, logic l_sgn,
                                     logic [ROB_W-1:0] l_tag, logic [DataW-1:0] l_res);
    operand_t r;
    r = op;
    if (op.pending) begin
      if (a_sgn && a_tag == tag) begin
        r = '{pending: 1'b0, value: a_res};
      end else if (l_sgn && l_tag == tag) begin
        r = '{pending: 1'b0, value: l_res};
      end
    end
    return r;
  endfunction

  // Free and ready vectors from registered state only.
  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      free_vec[i]  = ~ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy & ~ent_q[i].j.pending & ~ent_q[i].k.pending;
    end
  end

  reservation_station_pick #(.N(RS_SIZE)) u_pick_free (
    .req   (free_vec),
    .valid (free_valid),
    .idx   (free_idx)
  );

  reservation_station_pick #(.N(RS_SIZE)) u_pick_ready (
    .req   (ready_vec),
    .valid (ready_valid),
    .idx   (ready_idx)
  );

  assign bus.full = ~free_valid;

  // Next state: flush, or wakeup + issue + dispatch into disjoint slots.
  always_comb begin
    ent_d     = ent_q;
    alu_d     = alu_q;
    alu_d.sgn = 1'b0;
    if (clear) begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        ent_d[i].busy = 1'b0;
      end
    end else begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        if (ent_q[i].busy) begin
          ent_d[i].j = snoop(ent_q[i].j, ent_q[i].qj, bus.alu_cdb_sgn, bus.alu_cdb_rob_name,
                             bus.alu_cdb_result, bus.lsb_cdb_sgn, bus.lsb_cdb_rob_name,
                             bus.lsb_cdb_result);
          ent_d[i].k = snoop(ent_q[i].k, ent_q[i].qk, bus.alu_cdb_sgn, bus.alu_cdb_rob_name,
                             bus.alu_cdb_result, bus.lsb_cdb_sgn, bus.lsb_cdb_rob_name,
                             bus.lsb_cdb_result);
        end
      end
      if (ready_valid) begin
        alu_d.sgn               = 1'b1;
        alu_d.opcode            = ent_q[ready_idx].opcode;
        alu_d.rob_name          = ent_q[ready_idx].rob_name;
        alu_d.lhs               = ent_q[ready_idx].j.value;
        alu_d.rhs               = ent_q[ready_idx].k.value;
        ent_d[ready_idx].busy   = 1'b0;
      end
      // free_idx is a slot that is not busy now, so it never collides with the issued one.
      if (bus.disp_sgn && free_valid) begin
        ent_d[free_idx].busy     = 1'b1;
        ent_d[free_idx].opcode   = bus.disp_opcode;
        ent_d[free_idx].rob_name = bus.disp_rob_name;
        ent_d[free_idx].qj       = bus.disp_qj;
        ent_d[free_idx].qk       = bus.disp_qk;
        ent_d[free_idx].j = snoop('{pending: bus.disp_qj_busy, value: bus.disp_vj}, bus.disp_qj,
                                  bus.alu_cdb_sgn, bus.alu_cdb_rob_name, bus.alu_cdb_result,
                                  bus.lsb_cdb_sgn, bus.lsb_cdb_rob_name, bus.lsb_cdb_result);
        ent_d[free_idx].k = snoop('{pending: bus.disp_qk_busy, value: bus.disp_vk}, bus.disp_qk,
                                  bus.alu_cdb_sgn, bus.alu_cdb_rob_name, bus.alu_cdb_result,
                                  bus.lsb_cdb_sgn, bus.lsb_cdb_rob_name, bus.lsb_cdb_result);
      end
    end
  end

  // State register; rdy low freezes everything except the issue strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        ent_q[i] <= '0;
      end
      alu_q <= '0;
    end else if (!rdy) begin
      alu_q.sgn <= 1'b0;
    end else begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        ent_q[i] <= ent_d[i];
      end
      alu_q <= alu_d;
    end
  end

  assign bus.alu_sgn      = alu_q.sgn;
  assign bus.alu_opcode   = alu_q.opcode;
  assign bus.alu_rob_name = alu_q.rob_name;
  assign bus.alu_lhs      = alu_q.lhs;
  assign bus.alu_rhs      = alu_q.rhs;

endmodule
